opc5_serial_loader: RTL
=======================

Name: opc5_serial_loader

Overview:
- Serial-driven bus initiator for the OPC5 system: the second master on the CPU memory bus, alongside the CPU.
- Parses byte commands from the UART receive side and issues single-word reads/writes to RAM/IO.
- Returns reply bytes to the UART transmit side.
- Holds the CPU off the bus (cpu_hold) while loading; the external bus mux selects the loader whenever cpu_hold=1.

Parameters:
- HOLD_AT_RESET, 1, value of cpu_hold after reset (1 = boot into loader).
- ACK_CHAR, 8'h2E, reply byte for successful A/W/H commands.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte, valid only with rx_valid.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_data  out  8  reply byte.
- tx_valid  out  1  reply byte available.
- tx_ready  in  1  transmitter accepts byte (transfer when tx_valid&tx_ready at posedge).
- bus_addr  out  16  bus address.
- bus_dout  out  16  write data to bus.
- bus_din  in  16  read data from bus, valid in the same cycle as bus_req (RAM is clocked on negedge).
- bus_rnw  out  1  1=read, 0=write.
- bus_req  out  1  loader owns an access this cycle.
- cpu_hold  out  1  CPU held in reset; loader owns bus.
- err_overrun  out  1  sticky: rx byte arrived while not accepting.

Behaviour:
- Reset (async, immediate):
  - tx_valid=0, tx_data=0, bus_req=0, bus_rnw=1, bus_addr=0, bus_dout=0.
  - Pointer ptr=0, err_overrun=0, cpu_hold=HOLD_AT_RESET, state=IDLE.
  - Reset mid-command or mid-reply abandons it; tx_valid drops at once.
- Commands (first byte in IDLE):
  - 'A' 0x41 + addr_hi + addr_lo: ptr<=addr; reply ACK_CHAR.
  - 'W' 0x57 + d_hi + d_lo: write {d_hi,d_lo} at ptr; ptr<=ptr+1; reply ACK_CHAR.
  - 'R' 0x52: read word at ptr; reply hi byte then lo byte; ptr<=ptr+1.
  - 'H' 0x48: cpu_hold<=1; reply ACK_CHAR.
  - 'G' 0x47: reply 0x47; cpu_hold<=0 on the posedge where that reply is accepted.
  - Any other byte: reply '?' 0x3F; back to IDLE.
- A, W or R received while cpu_hold=0: reply '!' 0x21 immediately; operand bytes are not consumed and are parsed as new commands.
- States:
  - IDLE, ARG1, ARG2 collect operand bytes.
  - BUS_WR, BUS_RD: one cycle each.
  - TX1, TX2: reply bytes.
  - TX2 is used only for R, to send the lo byte.
- Bus access:
  - Exactly one cycle with bus_req=1 and bus_addr=ptr.
  - Write: bus_rnw=0, bus_dout=data.
  - Read: bus_rnw=1; bus_din captured at the closing posedge.
  - Outside an access: bus_req=0, bus_rnw=1.
  - bus_rnw is never 0 while bus_req=0.
- Latency:
  - W: last data byte -> BUS_WR the next cycle -> tx_valid the cycle after.
  - R: command byte -> BUS_RD the next cycle -> tx_valid with hi byte the cycle after.
- Tx handshake:
  - tx_data is held stable while tx_valid=1 and !tx_ready.
  - tx_valid falls, or advances to the next byte, only on acceptance.
  - Back-to-back acceptance allowed: hi accepted -> lo valid the next cycle.
- Overrun:
  - Bytes are accepted only in IDLE/ARG1/ARG2.
  - rx_valid in any other state drops the byte and sets err_overrun (sticky until reset).
- ptr wraps 0xFFFF -> 0x0000.
- Arguments are taken from rx bytes only; no timeout.

Decomposition:
- Package opc5_loader_pkg:
  - command byte constants (CMD_ADDR, CMD_WRITE, CMD_READ, CMD_HOLD, CMD_GO);
  - reply constants (RSP_ERR 0x3F, RSP_NOHOLD 0x21);
  - state enumeration.
- No sub-module: the FSM, pointer and tx holding register are a single module.

Test Plan:
- Reset with HOLD_AT_RESET=1; send 'A',0x01,0x00,'W',0xBE,0xEF -> two ACK 0x2E replies; exactly one cycle with bus_req=1, bus_rnw=0, bus_addr=0x0100, bus_dout=0xBEEF; ptr=0x0101.
- 'A',0x01,0x00 then 'R' with bus_din=0xBEEF in the access cycle -> tx bytes 0xBE then 0xEF; with tx_ready held low 5 cycles, tx_data stays 0xBE throughout.
- 'A',0xFF,0xFF,'W',0x12,0x34,'R' -> write at 0xFFFF, read at 0x0000 (wrap).
- 'G' -> reply 0x47, cpu_hold falls on acceptance; then 'R' -> reply 0x21 and no bus_req; 'H' -> 0x2E and cpu_hold=1.
- Byte 0x5A -> reply 0x3F; rx_valid pulse while a reply is pending (tx_ready=0) -> err_overrun=1, stays 1 until reset, byte ignored.
- Assert reset after 'A',0x12 mid-command -> outputs at reset values immediately; then 'R' reads address 0x0000.

Source files
------------

// File: rtl/opc5_loader_pkg.sv
// Shared constants and state encoding for the OPC5 serial loader.
package opc5_loader_pkg;

    // Command bytes recognised in the idle state
    localparam logic [7:0] CMD_ADDR   = 8'h41;  // 'A'
    localparam logic [7:0] CMD_WRITE  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_HOLD   = 8'h48;  // 'H'
    localparam logic [7:0] CMD_GO     = 8'h47;  // 'G'

    // Fixed reply bytes
    localparam logic [7:0] RSP_ERR    = 8'h3F;  // '?' unknown command
    localparam logic [7:0] RSP_NOHOLD = 8'h21;  // '!' bus command while CPU runs

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG1,
        ST_ARG2,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_TX1,
        ST_TX2
    } state_t;

    // Commands that touch the bus are refused unless the CPU is held
    function automatic logic needs_hold(input logic [7:0] cmd);
        return (cmd == CMD_ADDR) || (cmd == CMD_WRITE) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/opc5_serial_loader.sv
// Serial byte-command bus initiator: parses UART bytes, performs single-word
// RAM/IO accesses as second bus master and returns reply bytes.
module opc5_serial_loader
    import opc5_loader_pkg::*;
#(
    parameter bit         HOLD_AT_RESET = 1'b1,
    parameter logic [7:0] ACK_CHAR      = 8'h2E
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_rnw,
    output logic        bus_req,
    output logic        cpu_hold,
    output logic        err_overrun
);

    state_t      state;
    logic [15:0] ptr;
    logic [7:0]  arg_hi;
    logic        cmd_is_write;
    logic [7:0]  lo_byte;
    logic        two_bytes;
    logic        go_pending;

    // Command FSM, word pointer, bus access registers and reply holding register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            arg_hi       <= '0;
            cmd_is_write <= 1'b0;
            lo_byte      <= '0;
            two_bytes    <= 1'b0;
            go_pending   <= 1'b0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            bus_addr     <= '0;
            bus_dout     <= '0;
            bus_rnw      <= 1'b1;
            bus_req      <= 1'b0;
            cpu_hold     <= HOLD_AT_RESET;
            err_overrun  <= 1'b0;
        end else begin
            if (rx_valid && !(state inside {ST_IDLE, ST_ARG1, ST_ARG2}))
                err_overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (needs_hold(rx_data) && !cpu_hold) begin
                            tx_data   <= RSP_NOHOLD;
                            tx_valid  <= 1'b1;
                            two_bytes <= 1'b0;
                            state     <= ST_TX1;
                        end else begin
                            case (rx_data)
                                CMD_ADDR: begin
                                    cmd_is_write <= 1'b0;
                                    state        <= ST_ARG1;
                                end
                                CMD_WRITE: begin
                                    cmd_is_write <= 1'b1;
                                    state        <= ST_ARG1;
                                end
                                CMD_READ: begin
                                    bus_req  <= 1'b1;
                                    bus_rnw  <= 1'b1;
                                    bus_addr <= ptr;
                                    state    <= ST_BUS_RD;
                                end
                                CMD_HOLD: begin
                                    cpu_hold  <= 1'b1;
                                    tx_data   <= ACK_CHAR;
                                    tx_valid  <= 1'b1;
                                    two_bytes <= 1'b0;
                                    state     <= ST_TX1;
                                end
                                CMD_GO: begin
                                    go_pending <= 1'b1;
                                    tx_data    <= CMD_GO;
                                    tx_valid   <= 1'b1;
                                    two_bytes  <= 1'b0;
                                    state      <= ST_TX1;
                                end
                                default: begin
                                    tx_data   <= RSP_ERR;
                                    tx_valid  <= 1'b1;
                                    two_bytes <= 1'b0;
                                    state     <= ST_TX1;
                                end
                            endcase
                        end
                    end
                end

                ST_ARG1: begin
                    if (rx_valid) begin
                        arg_hi <= rx_data;
                        state  <= ST_ARG2;
                    end
                end

                ST_ARG2: begin
                    if (rx_valid) begin
                        if (cmd_is_write) begin
                            bus_req  <= 1'b1;
                            bus_rnw  <= 1'b0;
                            bus_addr <= ptr;
                            bus_dout <= {arg_hi, rx_data};
                            state    <= ST_BUS_WR;
                        end else begin
                            ptr       <= {arg_hi, rx_data};
                            tx_data   <= ACK_CHAR;
                            tx_valid  <= 1'b1;
                            two_bytes <= 1'b0;
                            state     <= ST_TX1;
                        end
                    end
                end

                ST_BUS_WR: begin
                    bus_req   <= 1'b0;
                    bus_rnw   <= 1'b1;
                    ptr       <= ptr + 16'd1;
                    tx_data   <= ACK_CHAR;
                    tx_valid  <= 1'b1;
                    two_bytes <= 1'b0;
                    state     <= ST_TX1;
                end

                ST_BUS_RD: begin
                    // RAM drives bus_din during the access cycle; capture it now
                    bus_req   <= 1'b0;
                    ptr       <= ptr + 16'd1;
                    tx_data   <= bus_din[15:8];
                    lo_byte   <= bus_din[7:0];
                    tx_valid  <= 1'b1;
                    two_bytes <= 1'b1;
                    state     <= ST_TX1;
                end

                ST_TX1: begin
                    if (tx_ready) begin
                        if (two_bytes) begin
                            tx_data <= lo_byte;
                            state   <= ST_TX2;
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= ST_IDLE;
                            if (go_pending) begin
                                cpu_hold   <= 1'b0;
                                go_pending <= 1'b0;
                            end
                        end
                    end
                end

                ST_TX2: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
